// File: rtl/path_measure_ctrl.sv
// Path-delay measurement controller: closes the delay chain into a ring oscillator
// for a programmed window and counts its synchronized rising edges.
module path_measure_ctrl #(
  parameter int CNT_W         = 16,
  parameter int WIN_W         = 16,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] windowCycles,
  input  logic             pathResult,
  output logic             ringEnable,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] edgeCount,
  output logic             overflow
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    RUN    = 3'd2,
    DRAIN  = 3'd3,
    REPORT = 3'd4
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic               syncA_r;
  logic               syncB_r;
  logic               syncPrev_r;
  logic               rise_s;
  logic [SET_W-1:0]   settleCnt_r;
  logic [WIN_W-1:0]   winLen_r;
  logic [WIN_W-1:0]   winCnt_r;
  logic               drainCnt_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_s;
  logic               ovf_r;
  logic               ovf_s;

  assign rise_s = syncB_r & ~syncPrev_r;

  // Two-flop synchronizer for the asynchronous chain output plus edge-history flop
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      syncA_r    <= 1'b0;
      syncB_r    <= 1'b0;
      syncPrev_r <= 1'b0;
    end else begin
      syncA_r    <= pathResult;
      syncB_r    <= syncA_r;
      syncPrev_r <= syncB_r;
    end
  end

  // Next-state logic; abort wins over everything in the measuring states
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start && !abort) state_s = SETTLE;
        else                 state_s = IDLE;
      end
      SETTLE: begin
        if (abort)                           state_s = IDLE;
        else if (settleCnt_r == SETTLE_LAST) state_s = (winLen_r == '0) ? DRAIN : RUN;
        else                                 state_s = SETTLE;
      end
      RUN: begin
        if (abort)                                        state_s = IDLE;
        else if (winCnt_r == winLen_r - WIN_W'(1'b1))     state_s = DRAIN;
        else                                              state_s = RUN;
      end
      DRAIN: begin
        if (abort)           state_s = IDLE;
        else if (drainCnt_r) state_s = REPORT;
        else                 state_s = DRAIN;
      end
      REPORT:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Saturating edge counter with sticky overflow, cleared while settling
  always_comb begin
    cnt_s = cnt_r;
    ovf_s = ovf_r;
    if (state_r == SETTLE) begin
      cnt_s = '0;
      ovf_s = 1'b0;
    end else if ((state_r == RUN || state_r == DRAIN) && rise_s) begin
      if (cnt_r == CNT_MAX) ovf_s = 1'b1;
      else                  cnt_s = cnt_r + CNT_W'(1'b1);
    end else begin
      cnt_s = cnt_r;
      ovf_s = ovf_r;
    end
  end

  // State register and phase counters
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_r     <= IDLE;
      settleCnt_r <= '0;
      winLen_r    <= '0;
      winCnt_r    <= '0;
      drainCnt_r  <= 1'b0;
      cnt_r       <= '0;
      ovf_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      settleCnt_r <= (state_r == SETTLE) ? settleCnt_r + SET_W'(1'b1) : '0;
      winCnt_r    <= (state_r == RUN) ? winCnt_r + WIN_W'(1'b1) : '0;
      drainCnt_r  <= (state_r == DRAIN) ? ~drainCnt_r : 1'b0;
      cnt_r       <= cnt_s;
      ovf_r       <= ovf_s;
      if (state_r == IDLE && state_s == SETTLE) winLen_r <= windowCycles;
      else                                      winLen_r <= winLen_r;
    end
  end

  // Registered outputs decoded from the next state so they line up with the state they describe
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ringEnable <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      edgeCount  <= '0;
      overflow   <= 1'b0;
    end else begin
      ringEnable <= (state_s == RUN);
      busy       <= (state_s != IDLE);
      done       <= (state_s == REPORT);
      // Result is captured on entry to REPORT so it is valid together with done
      if (state_s == REPORT) begin
        edgeCount <= cnt_s;
        overflow  <= ovf_s;
      end else begin
        edgeCount <= edgeCount;
        overflow  <= overflow;
      end
    end
  end

endmodule

// File: tb/tb_path_measure_ctrl.sv
// Directed bench for path_measure_ctrl: a default instance plus a 4-bit-counter
// instance for saturation, driven from one cycle-accurate stimulus task.
module tb_path_measure_ctrl;

  logic        clk = 1'b0;
  logic        rstN;
  logic        start;
  logic        abort;
  logic [15:0] windowCycles;
  logic        pathResult;
  logic        ringEnable, busy, done, overflow;
  logic [15:0] edgeCount;
  logic        ringEnable2, busy2, done2, overflow2;
  logic [3:0]  edgeCount2;

  int testsRun    = 0;
  int testsFailed = 0;
  int lat, ringHi, doneCnt, probeRing, probeBusy, idleDone;

  always #5 clk = ~clk;

  path_measure_ctrl dut (
    .clk(clk), .rstN(rstN), .start(start), .abort(abort),
    .windowCycles(windowCycles), .pathResult(pathResult),
    .ringEnable(ringEnable), .busy(busy), .done(done),
    .edgeCount(edgeCount), .overflow(overflow)
  );

  path_measure_ctrl #(.CNT_W(4)) dutSat (
    .clk(clk), .rstN(rstN), .start(start), .abort(abort),
    .windowCycles(windowCycles), .pathResult(pathResult),
    .ringEnable(ringEnable2), .busy(busy2), .done(done2),
    .edgeCount(edgeCount2), .overflow(overflow2)
  );

  task automatic checkVal(input string tag, input int got, input int exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Requests a measurement in the current cycle, then runs maxCyc cycles.
  // pathResult has a half-period of 'half' cycles (0 = held low).
  task automatic runMeas(input logic [15:0] win, input int half, input int abortAt,
                         input int restartAt, input int maxCyc,
                         output int latency, output int ringCycles, output int doneSeen,
                         output int pRing, output int pBusy);
    start = 1'b1; windowCycles = win; pathResult = 1'b0; abort = 1'b0;
    latency = 0; ringCycles = 0; doneSeen = 0; pRing = -1; pBusy = -1;
    for (int n = 1; n <= maxCyc; n++) begin
      @(posedge clk); #1;
      start = (n == restartAt);
      abort = (n == abortAt);
      if (half == 0) pathResult = 1'b0;
      else           pathResult = ((n / half) % 2) == 1;
      if (ringEnable) ringCycles++;
      if (done) begin
        doneSeen++;
        if (latency == 0) latency = n;
      end
      if (n == abortAt + 1) begin
        pRing = int'(ringEnable);
        pBusy = int'(busy);
      end
    end
    start = 1'b0; abort = 1'b0; pathResult = 1'b0;
  endtask

  initial begin
    rstN = 1'b0; start = 1'b0; abort = 1'b0; windowCycles = 16'd0; pathResult = 1'b0;
    #3;
    checkVal("rst_ring", int'(ringEnable), 0);
    checkVal("rst_busy", int'(busy), 0);
    checkVal("rst_done", int'(done), 0);
    checkVal("rst_count", int'(edgeCount), 0);
    checkVal("rst_ovf", int'(overflow), 0);
    @(posedge clk); #1;
    rstN = 1'b1;

    // Basic 100-cycle window, rising edge every 4 clk
    runMeas(16'd100, 2, 0, 0, 112, lat, ringHi, doneCnt, probeRing, probeBusy);
    checkVal("basic_latency", lat, 107);
    checkVal("basic_ring_cycles", ringHi, 100);
    checkVal("basic_done_count", doneCnt, 1);
    checkVal("basic_count", int'(edgeCount), 25);
    checkVal("basic_ovf", int'(overflow), 0);
    checkVal("basic_busy_after", int'(busy), 0);

    // Abort in the 10th RUN cycle
    runMeas(16'd100, 2, 14, 0, 130, lat, ringHi, doneCnt, probeRing, probeBusy);
    checkVal("abort_ring_next", probeRing, 0);
    checkVal("abort_busy_next", probeBusy, 0);
    checkVal("abort_ring_cycles", ringHi, 10);
    checkVal("abort_no_done", doneCnt, 0);
    checkVal("abort_count_kept", int'(edgeCount), 25);

    // Zero window skips RUN
    runMeas(16'd0, 0, 0, 0, 12, lat, ringHi, doneCnt, probeRing, probeBusy);
    checkVal("zero_latency", lat, 7);
    checkVal("zero_ring_cycles", ringHi, 0);
    checkVal("zero_count", int'(edgeCount), 0);

    // Second start during RUN is ignored
    runMeas(16'd100, 2, 0, 50, 120, lat, ringHi, doneCnt, probeRing, probeBusy);
    checkVal("restart_done_count", doneCnt, 1);
    checkVal("restart_latency", lat, 107);
    checkVal("restart_count", int'(edgeCount), 25);

    // start together with abort in IDLE is not accepted
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    checkVal("idle_abort_busy", int'(busy), 0);
    idleDone = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done || busy) idleDone++;
    end
    checkVal("idle_abort_activity", idleDone, 0);

    // Saturation on the 4-bit instance; default instance counts 101 edges
    runMeas(16'd200, 1, 0, 0, 212, lat, ringHi, doneCnt, probeRing, probeBusy);
    checkVal("sat_latency", lat, 207);
    checkVal("sat_count4", int'(edgeCount2), 15);
    checkVal("sat_ovf4", int'(overflow2), 1);
    checkVal("sat_count16", int'(edgeCount), 101);
    checkVal("sat_ovf16", int'(overflow), 0);

    // Next measurement clears the sticky overflow
    runMeas(16'd10, 0, 0, 0, 20, lat, ringHi, doneCnt, probeRing, probeBusy);
    checkVal("short_latency", lat, 17);
    checkVal("clear_count4", int'(edgeCount2), 0);
    checkVal("clear_ovf4", int'(overflow2), 0);

    // Asynchronous reset between clock edges during RUN
    runMeas(16'd100, 2, 0, 0, 30, lat, ringHi, doneCnt, probeRing, probeBusy);
    checkVal("pre_reset_ring", int'(ringEnable), 1);
    #2 rstN = 1'b0;
    #1;
    checkVal("async_ring", int'(ringEnable), 0);
    checkVal("async_busy", int'(busy), 0);
    checkVal("async_done", int'(done), 0);
    checkVal("async_count", int'(edgeCount), 0);
    checkVal("async_ovf", int'(overflow), 0);
    checkVal("async_ring4", int'(ringEnable2), 0);
    checkVal("async_busy4", int'(busy2), 0);
    checkVal("async_done4", int'(done2), 0);
    @(posedge clk); #1;
    rstN = 1'b1;
    runMeas(16'd100, 2, 0, 0, 112, lat, ringHi, doneCnt, probeRing, probeBusy);
    checkVal("post_reset_latency", lat, 107);
    checkVal("post_reset_done_count", doneCnt, 1);
    checkVal("post_reset_count", int'(edgeCount), 25);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
